bram_port_arbiter: RTL and testbench
====================================

// Module: bram_port_arbiter
// PURPOSE
// - Shares one port of the dual-port BRAM between two Avalon-MM requesters (e.g. data port + debug/DMA master).
// - Issues at most one access per cycle to the BRAM port.
// - Stalls the losing requester with waitrequest.
// - Routes the 1-cycle-latency read response back to the originator with readdatavalid.
// - Sits between the requesters and the BRAM wrapper; adds no latency to the granted request.
// PARAMETERS
// ADDRESS_WIDTH   12             word address width, matches BRAM
// BYTE_WIDTH      8              bits per byte lane
// BYTES_PER_WORD  4              byte lanes per word
// POLICY          "ROUND_ROBIN"  "ROUND_ROBIN" or "FIXED" (r0 has priority)
// MAX_STREAK      4              FIXED only: max consecutive r0 grants while r1 waits, 1..15
// PORTS
// clock             in   1        single clock
// reset             in   1        synchronous, active-high
// r0_address        in   ADDRESS_WIDTH            requester 0 word address
// r0_byteenable     in   BYTES_PER_WORD           lane enables
// r0_read           in   1                        read request
// r0_write          in   1                        write request
// r0_writedata      in   BYTES_PER_WORD*BYTE_WIDTH
// r0_readdata       out  BYTES_PER_WORD*BYTE_WIDTH  = mem_readdata (broadcast)
// r0_readdatavalid  out  1                        r0 read data valid this cycle
// r0_waitrequest    out  1                        request not accepted this cycle
// r1_*              --   --                       identical set for requester 1
// mem_address       out  ADDRESS_WIDTH            to BRAM port
// mem_byteenable    out  BYTES_PER_WORD
// mem_read          out  1
// mem_write         out  1
// mem_writedata     out  BYTES_PER_WORD*BYTE_WIDTH
// mem_readdata      in   BYTES_PER_WORD*BYTE_WIDTH  valid 1 cycle after mem_read
// BEHAVIOUR
// - reqN = rN_read | rN_write. Grant is combinational from reqN and registered state, same cycle.
// - Granted requester: waitrequest=0; its address/byteenable/writedata/read/write driven onto mem_*.
// - No grant: mem_read=mem_write=0; mem_address/mem_writedata = r0 values.
// - Loser with req=1: waitrequest=1. Requester with req=0: waitrequest=0 (Avalon idle).
// - Requesters hold signals stable while waitrequest=1.
// - ROUND_ROBIN: 1-bit last_grant register.
//   - Both request: grant the one != last_grant.
//   - Single request: grant it (0-cycle wait). Update last_grant on every grant.
// - FIXED: r0 wins ties. 4-bit streak counter:
//   - increments on an r0 grant while r1 requests; clears on any r1 grant or when r1 idle.
//   - streak==MAX_STREAK with both requesting -> grant r1.
// - Read response: regs rv_valid, rv_id set on cycle of a granted read.
//   - Next cycle: r<rv_id>_readdatavalid=1, other 0. Back-to-back reads give back-to-back valids.
// - Write completes on acceptance; no response.
// - Same requester read&write together: illegal; simulation assertion; treated as write.
// - Reset (sync):
//   - rv_valid=0, last_grant=1 (r0 wins first RR tie), streak=0.
//   - While reset=1: both waitrequest=1, mem_read=mem_write=0, readdatavalid=0.
//   - A read granted the cycle before reset asserts is dropped (no readdatavalid).
// - Readdata is unregistered pass-through of mem_readdata; only readdatavalid qualifies it.
// STRUCTURE
// - Package bram_arb_pkg:
//   - typedef enum logic {REQ0, REQ1} req_id_t;
//   - typedef enum {ARB_RR, ARB_FIXED} arb_policy_t;
//   - localparam STREAK_WIDTH = 4.
// - One sub-module bram_arb_pick: reqs, last_grant, streak, policy -> grant_valid, grant_id (combinational).
// - Top keeps all registers and the mem mux.
// TESTING
// - Single r0 read addr 0x010 (mem holds 0xDEADBEEF) -> waitrequest=0 same cycle;
//   next cycle r0_readdatavalid=1, r0_readdata=0xDEADBEEF, r1_readdatavalid=0.
// - RR, r0 and r1 both read continuously for 6 cycles after reset ->
//   grants r0,r1,r0,r1,r0,r1; each waits alternate cycles; valids alternate 1 cycle later.
// - FIXED MAX_STREAK=4, r0 always reading, r1 reads from cycle 0 ->
//   r0 granted cycles 0-3, r1 cycle 4, r0 resumes cycle 5.
// - r0 write 0x11223344 be=4'b0101 addr 5, same cycle r1 read addr 5 (r1 loses) ->
//   r1 read next cycle returns lanes 0,2 updated.
// - Reset asserted the cycle after a granted r1 read ->
//   no r1_readdatavalid; both waitrequest=1 during reset; first post-reset tie goes to r0.
// - Idle both ports 10 cycles -> mem_read=mem_write=0, waitrequests=0, no readdatavalid.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types for the BRAM port arbiter.
// No logic, types and constants only.
// No flow control of its own.
package bram_arb_pkg;

    // Identifies which requester owns a grant or a pending read response.
    typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_id_t;

    // Arbitration scheme chosen at elaboration time.
    typedef enum {ARB_RR, ARB_FIXED} arb_policy_t;

    // Width of the FIXED-policy starvation counter; holds MAX_STREAK up to 15.
    localparam int STREAK_WIDTH = 4;

endpackage

// File: rtl/bram_arb_pick.sv
// Grant decision for two requesters sharing one BRAM port.
// Purely combinational, zero latency.
// The loser of a tie is told through the grant outputs and is stalled by the parent.
module bram_arb_pick
    import bram_arb_pkg::*;
#(
    parameter arb_policy_t POLICY     = ARB_RR,
    parameter int          MAX_STREAK = 4
) (
    input  logic                    req0,
    input  logic                    req1,
    input  req_id_t                 last_grant,
    input  logic [STREAK_WIDTH-1:0] streak,
    output logic                    grant_valid,
    output req_id_t                 grant_id
);

    localparam logic [STREAK_WIDTH-1:0] STREAK_LIMIT = STREAK_WIDTH'(MAX_STREAK);

    // A lone requester always wins; ties go by alternation or by r0 priority with a starvation cap.
    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = REQ0;
        if (req0 && req1) begin
            if (POLICY == ARB_RR) begin
                grant_id = (last_grant == REQ0) ? REQ1 : REQ0;
            end else begin
                grant_id = (streak == STREAK_LIMIT) ? REQ1 : REQ0;
            end
        end else if (req1) begin
            grant_id = REQ1;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between two Avalon-MM requesters and steers read data back.
// Granted request reaches mem_* in the same cycle; readdatavalid follows one cycle later.
// The losing requester sees waitrequest=1 and must hold its request; both stall during reset.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int    ADDRESS_WIDTH  = 12,
    parameter int    BYTE_WIDTH     = 8,
    parameter int    BYTES_PER_WORD = 4,
    parameter string POLICY         = "ROUND_ROBIN",
    parameter int    MAX_STREAK     = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [ADDRESS_WIDTH-1:0]             r0_address,
    input  logic [BYTES_PER_WORD-1:0]            r0_byteenable,
    input  logic                                 r0_read,
    input  logic                                 r0_write,
    input  logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] r0_writedata,
    output logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] r0_readdata,
    output logic                                 r0_readdatavalid,
    output logic                                 r0_waitrequest,
    input  logic [ADDRESS_WIDTH-1:0]             r1_address,
    input  logic [BYTES_PER_WORD-1:0]            r1_byteenable,
    input  logic                                 r1_read,
    input  logic                                 r1_write,
    input  logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] r1_writedata,
    output logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] r1_readdata,
    output logic                                 r1_readdatavalid,
    output logic                                 r1_waitrequest,
    output logic [ADDRESS_WIDTH-1:0]             mem_address,
    output logic [BYTES_PER_WORD-1:0]            mem_byteenable,
    output logic                                 mem_read,
    output logic                                 mem_write,
    output logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] mem_writedata,
    input  logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] mem_readdata
);

    localparam arb_policy_t ARB_POLICY = (POLICY == "FIXED") ? ARB_FIXED : ARB_RR;

    logic                    req0;
    logic                    req1;
    logic                    pick_valid;
    req_id_t                 pick_id;
    logic                    grant_valid;
    req_id_t                 grant_id;
    req_id_t                 last_grant;
    logic [STREAK_WIDTH-1:0] streak;
    logic                    rv_valid;
    req_id_t                 rv_id;

    assign req0 = r0_read | r0_write;
    assign req1 = r1_read | r1_write;

    bram_arb_pick #(
        .POLICY     (ARB_POLICY),
        .MAX_STREAK (MAX_STREAK)
    ) u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (last_grant),
        .streak      (streak),
        .grant_valid (pick_valid),
        .grant_id    (pick_id)
    );

    // Nothing is accepted while reset is held, regardless of what the requesters present.
    assign grant_valid = pick_valid & ~reset;
    assign grant_id    = pick_id;

    assign r0_waitrequest = reset | (req0 & ~(grant_valid & (grant_id == REQ0)));
    assign r1_waitrequest = reset | (req1 & ~(grant_valid & (grant_id == REQ1)));

    // Read data is broadcast unregistered; only readdatavalid says whose it is.
    assign r0_readdata      = mem_readdata;
    assign r1_readdata      = mem_readdata;
    assign r0_readdatavalid = rv_valid & ~reset & (rv_id == REQ0);
    assign r1_readdatavalid = rv_valid & ~reset & (rv_id == REQ1);

    // Steer the winner onto the BRAM port; an idle port shows r0's address/data with no strobe.
    always_comb begin
        mem_address    = r0_address;
        mem_byteenable = r0_byteenable;
        mem_writedata  = r0_writedata;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        if (grant_valid) begin
            if (grant_id == REQ1) begin
                mem_address    = r1_address;
                mem_byteenable = r1_byteenable;
                mem_writedata  = r1_writedata;
                mem_write      = r1_write;
                mem_read       = r1_read & ~r1_write;
            end else begin
                mem_write      = r0_write;
                mem_read       = r0_read & ~r0_write;
            end
        end
    end

    // Track the response owner, the last winner, and how long r1 has been starved by r0.
    always_ff @(posedge clock) begin
        if (reset) begin
            rv_valid   <= 1'b0;
            rv_id      <= REQ0;
            last_grant <= REQ1;
            streak     <= '0;
        end else begin
            rv_valid <= mem_read;
            if (grant_valid) begin
                rv_id      <= grant_id;
                last_grant <= grant_id;
            end
            if (!req1 || (grant_valid && grant_id == REQ1)) begin
                streak <= '0;
            end else if (grant_valid && grant_id == REQ0 && streak != '1) begin
                streak <= streak + STREAK_WIDTH'(1);
            end
        end
    end

    // A simultaneous read and write from one requester is a protocol error; it is served as a write.
    r0_rw_exclusive: assert property (@(posedge clock) disable iff (reset) !(r0_read && r0_write));
    r1_rw_exclusive: assert property (@(posedge clock) disable iff (reset) !(r1_read && r1_write));

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter side by side against a behavioural model.
// Each arbiter talks to its own one-cycle-latency BRAM model.
// Requesters hold their request until waitrequest drops, as Avalon requires.
module tb_bram_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int MAX_STREAK = 4;
    localparam logic [1:0] K_IDLE = 2'd0;
    localparam logic [1:0] K_RD   = 2'd1;
    localparam logic [1:0] K_WR   = 2'd2;

    typedef struct packed {
        logic [1:0]    kind;
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [DW-1:0] data;
    } op_t;

    logic clock = 1'b0;
    logic reset;
    logic rst_next;
    always #5 clock = ~clock;

    // Index [d][r]: d=0 round-robin arbiter, d=1 fixed-priority arbiter; r = requester.
    logic [AW-1:0] i_addr [2][2];
    logic [3:0]    i_be   [2][2];
    logic          i_rd   [2][2];
    logic          i_wr   [2][2];
    logic [DW-1:0] i_wd   [2][2];
    wire  [DW-1:0] o_rdata[2][2];
    wire           o_rdv  [2][2];
    wire           o_wait [2][2];
    wire  [AW-1:0] m_addr [2];
    wire  [3:0]    m_be   [2];
    wire           m_rd   [2];
    wire           m_wr   [2];
    wire  [DW-1:0] m_wd   [2];
    logic [DW-1:0] m_rdata[2];
    logic [DW-1:0] bmem   [2][4096];

    bram_port_arbiter #(.POLICY("ROUND_ROBIN"), .MAX_STREAK(MAX_STREAK)) u_rr (
        .clock(clock), .reset(reset),
        .r0_address(i_addr[0][0]), .r0_byteenable(i_be[0][0]), .r0_read(i_rd[0][0]),
        .r0_write(i_wr[0][0]), .r0_writedata(i_wd[0][0]), .r0_readdata(o_rdata[0][0]),
        .r0_readdatavalid(o_rdv[0][0]), .r0_waitrequest(o_wait[0][0]),
        .r1_address(i_addr[0][1]), .r1_byteenable(i_be[0][1]), .r1_read(i_rd[0][1]),
        .r1_write(i_wr[0][1]), .r1_writedata(i_wd[0][1]), .r1_readdata(o_rdata[0][1]),
        .r1_readdatavalid(o_rdv[0][1]), .r1_waitrequest(o_wait[0][1]),
        .mem_address(m_addr[0]), .mem_byteenable(m_be[0]), .mem_read(m_rd[0]),
        .mem_write(m_wr[0]), .mem_writedata(m_wd[0]), .mem_readdata(m_rdata[0])
    );

    bram_port_arbiter #(.POLICY("FIXED"), .MAX_STREAK(MAX_STREAK)) u_fixed (
        .clock(clock), .reset(reset),
        .r0_address(i_addr[1][0]), .r0_byteenable(i_be[1][0]), .r0_read(i_rd[1][0]),
        .r0_write(i_wr[1][0]), .r0_writedata(i_wd[1][0]), .r0_readdata(o_rdata[1][0]),
        .r0_readdatavalid(o_rdv[1][0]), .r0_waitrequest(o_wait[1][0]),
        .r1_address(i_addr[1][1]), .r1_byteenable(i_be[1][1]), .r1_read(i_rd[1][1]),
        .r1_write(i_wr[1][1]), .r1_writedata(i_wd[1][1]), .r1_readdata(o_rdata[1][1]),
        .r1_readdatavalid(o_rdv[1][1]), .r1_waitrequest(o_wait[1][1]),
        .mem_address(m_addr[1]), .mem_byteenable(m_be[1]), .mem_read(m_rd[1]),
        .mem_write(m_wr[1]), .mem_writedata(m_wd[1]), .mem_readdata(m_rdata[1])
    );

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        if (a == 12'h010) return 32'hDEADBEEF;
        return {8'hA5, a[7:0], 4'h3, a};
    endfunction

    // BRAM models: byte-lane writes, registered read data, contents reloaded during reset.
    always @(posedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                for (int i = 0; i < 4096; i++) bmem[d][i] <= init_word(AW'(i));
            end else begin
                if (m_wr[d])
                    for (int b = 0; b < 4; b++)
                        if (m_be[d][b]) bmem[d][m_addr[d]][b*8 +: 8] <= m_wd[d][b*8 +: 8];
                if (m_rd[d]) m_rdata[d] <= bmem[d][m_addr[d]];
            end
        end
    end

    // Reference model state.
    op_t           opq [4][$];
    op_t           cur [2][2];
    bit            busy[2][2];
    int            last_srv[2];
    int            run0[2];
    bit            pend[2];
    int            pend_id[2];
    logic [DW-1:0] pend_dat[2];
    logic [DW-1:0] ref_mem[2][4096];
    int            glog[2][$];
    logic [32:0]   rlog[2][$];
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    function automatic op_t mk(input logic [1:0] k, input int a, input logic [3:0] be,
                               input logic [DW-1:0] dat);
        op_t o;
        o.kind = k; o.addr = AW'(a); o.be = be; o.data = dat;
        return o;
    endfunction

    task automatic push(input int d, input int r, input op_t o);
        opq[d*2+r].push_back(o);
    endtask

    function automatic int gat(input int d, input int i);
        if (i < glog[d].size()) return glog[d][i];
        return -2;
    endfunction

    function automatic logic [32:0] rat(input int d, input int i);
        if (i < rlog[d].size()) return rlog[d][i];
        return '1;
    endfunction

    task automatic clear_logs();
        for (int d = 0; d < 2; d++) begin
            glog[d].delete();
            rlog[d].delete();
        end
    endtask

    // Predict one cycle for arbiter d from the rules, compare, then advance the model.
    task automatic model_step(input int d);
        bit  want0, want1;
        int  win;
        op_t g;
        want0 = busy[d][0];
        want1 = busy[d][1];
        win = -1;
        g = '0;
        if (!reset) begin
            if (want0 && want1) begin
                if (d == 0) win = 1 - last_srv[d];
                else        win = (run0[d] >= MAX_STREAK) ? 1 : 0;
            end else if (want0) win = 0;
            else if (want1) win = 1;
        end
        if (win >= 0) g = cur[d][win];
        for (int r = 0; r < 2; r++)
            check_val($sformatf("wait d%0d r%0d", d, r), 64'(o_wait[d][r]),
                      64'(reset || (busy[d][r] && win != r)));
        check_val($sformatf("mem_read d%0d", d), 64'(m_rd[d]), 64'(win >= 0 && g.kind == K_RD));
        check_val($sformatf("mem_write d%0d", d), 64'(m_wr[d]), 64'(win >= 0 && g.kind == K_WR));
        check_val($sformatf("mem_address d%0d", d), 64'(m_addr[d]),
                  64'((win >= 0) ? g.addr : cur[d][0].addr));
        if (win >= 0 && g.kind == K_WR) begin
            check_val($sformatf("mem_writedata d%0d", d), 64'(m_wd[d]), 64'(g.data));
            check_val($sformatf("mem_byteenable d%0d", d), 64'(m_be[d]), 64'(g.be));
        end
        for (int r = 0; r < 2; r++)
            check_val($sformatf("readdatavalid d%0d r%0d", d, r), 64'(o_rdv[d][r]),
                      64'(!reset && pend[d] && pend_id[d] == r));
        if (!reset && pend[d])
            check_val($sformatf("readdata d%0d", d), 64'(o_rdata[d][pend_id[d]]), 64'(pend_dat[d]));
        // DUT-observed grant and response history for the directed checks.
        if (m_rd[d] || m_wr[d]) glog[d].push_back((!o_wait[d][0] && busy[d][0]) ? 0 : 1);
        else                    glog[d].push_back(-1);
        for (int r = 0; r < 2; r++)
            if (o_rdv[d][r]) rlog[d].push_back({1'(r), o_rdata[d][r]});
        if (reset) begin
            last_srv[d] = 1;
            run0[d] = 0;
            pend[d] = 0;
            for (int i = 0; i < 4096; i++) ref_mem[d][i] = init_word(AW'(i));
        end else begin
            pend[d] = (win >= 0 && g.kind == K_RD);
            pend_id[d] = win;
            if (pend[d]) pend_dat[d] = ref_mem[d][g.addr];
            if (win >= 0 && g.kind == K_WR)
                for (int b = 0; b < 4; b++)
                    if (g.be[b]) ref_mem[d][g.addr][b*8 +: 8] = g.data[b*8 +: 8];
            if (win >= 0) begin
                last_srv[d] = win;
                busy[d][win] = 0;
            end
            if (win == 0 && want1) run0[d]++;
            else                   run0[d] = 0;
        end
    endtask

    // One clock: present requests just after the edge, check mid-cycle.
    task automatic run_cycle();
        @(posedge clock);
        #1;
        reset = rst_next;
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 2; r++) begin
                if (!busy[d][r]) begin
                    op_t o;
                    if (opq[d*2+r].size() > 0) o = opq[d*2+r].pop_front();
                    else begin
                        o = '0;
                        o.addr = AW'($urandom);
                    end
                    cur[d][r] = o;
                    busy[d][r] = (o.kind != K_IDLE);
                end
                i_addr[d][r] = cur[d][r].addr;
                i_be[d][r]   = cur[d][r].be;
                i_rd[d][r]   = (cur[d][r].kind == K_RD);
                i_wr[d][r]   = (cur[d][r].kind == K_WR);
                i_wd[d][r]   = cur[d][r].data;
            end
        end
        @(negedge clock);
        for (int d = 0; d < 2; d++) model_step(d);
    endtask

    initial begin
        int nz;
        reset = 1'b1;
        rst_next = 1'b1;
        for (int d = 0; d < 2; d++) begin
            last_srv[d] = 1;
            run0[d] = 0;
        end
        repeat (3) run_cycle();
        rst_next = 1'b0;

        // Both requesters read back to back on each arbiter straight out of reset.
        clear_logs();
        for (int k = 0; k < 3; k++) begin
            push(0, 0, mk(K_RD, 16 + k, 4'hF, 0));
            push(0, 1, mk(K_RD, 32 + k, 4'hF, 0));
        end
        for (int k = 0; k < 6; k++) push(1, 0, mk(K_RD, k, 4'hF, 0));
        push(1, 1, mk(K_RD, 9, 4'hF, 0));
        repeat (9) run_cycle();
        begin
            int rr_exp[6]  = '{0, 1, 0, 1, 0, 1};
            int fx_exp[6]  = '{0, 0, 0, 0, 1, 0};
            for (int k = 0; k < 6; k++) begin
                check_val($sformatf("rr_grant[%0d]", k), 64'(gat(0, k)), 64'(rr_exp[k]));
                check_val($sformatf("fixed_grant[%0d]", k), 64'(gat(1, k)), 64'(fx_exp[k]));
                check_val($sformatf("rr_valid_owner[%0d]", k), 64'(rat(0, k) >> 32), 64'(rr_exp[k]));
            end
            check_val("rr_valid_count", 64'(rlog[0].size()), 64'd6);
        end

        // r0 partial write collides with r1 read of the same word; r1 sees the merged word.
        clear_logs();
        push(0, 0, mk(K_WR, 5, 4'b0101, 32'h11223344));
        push(0, 1, mk(K_RD, 5, 4'hF, 0));
        repeat (4) run_cycle();
        check_val("wr_rd_first_grant", 64'(gat(0, 0)), 64'd0);
        check_val("wr_rd_second_grant", 64'(gat(0, 1)), 64'd1);
        check_val("wr_rd_resp_count", 64'(rlog[0].size()), 64'd1);
        check_val("wr_rd_merged", 64'(rat(0, 0)),
                  64'({1'b1, (init_word(12'd5) & 32'hFF00FF00) | 32'h00220044}));

        // Single read of the preloaded word.
        clear_logs();
        push(0, 0, mk(K_RD, 12'h010, 4'hF, 0));
        repeat (3) run_cycle();
        check_val("single_read_grant", 64'(gat(0, 0)), 64'd0);
        check_val("single_read_data", 64'(rat(0, 0)), 64'({1'b0, 32'hDEADBEEF}));
        check_val("single_read_count", 64'(rlog[0].size()), 64'd1);

        // Reset lands right after a granted r1 read; that response must vanish.
        clear_logs();
        push(0, 1, mk(K_RD, 3, 4'hF, 0));
        run_cycle();
        push(0, 0, mk(K_RD, 7, 4'hF, 0));
        push(0, 1, mk(K_RD, 8, 4'hF, 0));
        rst_next = 1'b1;
        repeat (2) run_cycle();
        rst_next = 1'b0;
        repeat (4) run_cycle();
        check_val("rst_pre_grant", 64'(gat(0, 0)), 64'd1);
        check_val("rst_during_grant", 64'(gat(0, 1)), 64'hFFFF_FFFF_FFFF_FFFF);
        check_val("rst_first_tie", 64'(gat(0, 3)), 64'd0);
        check_val("rst_second_tie", 64'(gat(0, 4)), 64'd1);
        check_val("rst_resp_count", 64'(rlog[0].size()), 64'd2);
        check_val("rst_resp0", 64'(rat(0, 0)), 64'({1'b0, init_word(12'd7)}));
        check_val("rst_resp1", 64'(rat(0, 1)), 64'({1'b1, init_word(12'd8)}));

        // Fully idle ports.
        clear_logs();
        repeat (10) run_cycle();
        nz = 0;
        for (int d = 0; d < 2; d++)
            foreach (glog[d][k]) if (glog[d][k] != -1) nz++;
        check_val("idle_grants", 64'(nz), 64'd0);
        check_val("idle_valids", 64'(rlog[0].size() + rlog[1].size()), 64'd0);

        // Random traffic over a small address window, with occasional resets.
        for (int c = 0; c < 800; c++) begin
            for (int d = 0; d < 2; d++) begin
                for (int r = 0; r < 2; r++) begin
                    if (opq[d*2+r].size() == 0) begin
                        int k;
                        logic [1:0] kind;
                        k = int'($urandom_range(0, 3));
                        kind = (k == 0) ? K_IDLE : ((k == 3) ? K_WR : K_RD);
                        push(d, r, mk(kind, int'($urandom_range(0, 15)), 4'($urandom), $urandom));
                    end
                end
            end
            rst_next = ($urandom_range(0, 59) == 0);
            run_cycle();
        end
        rst_next = 1'b0;
        repeat (3) run_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
